// File: rtl/md_unit_pkg.sv
// Shared multiply/divide definitions: operation codes and default latencies.
package md_unit_pkg;

    localparam logic [2:0] md_mult  = 3'b001;
    localparam logic [2:0] md_multu = 3'b010;
    localparam logic [2:0] md_div   = 3'b011;
    localparam logic [2:0] md_divu  = 3'b100;

    localparam int unsigned DEF_MULT_CYCLES = 5;
    localparam int unsigned DEF_DIV_CYCLES  = 10;

    function automatic logic is_md_op(input logic [2:0] op);
        return (op == md_mult) || (op == md_multu) || (op == md_div) || (op == md_divu);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == md_div) || (op == md_divu);
    endfunction

endpackage

// File: rtl/md_unit_arith.sv
// Combinational mult/div datapath producing the {HI,LO} result and a divide-by-zero flag.
module md_arith
    import md_unit_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  mdctr,
    output logic [31:0] rhi,
    output logic [31:0] rlo,
    output logic        dz
);

    logic        w_signed;
    logic [63:0] w_ea;
    logic [63:0] w_eb;
    logic [63:0] w_prod;
    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_q;
    logic [31:0] w_r;
    logic [31:0] w_qs;
    logic [31:0] w_rs;

    // Signed division works on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
    always_comb begin
        w_signed = (mdctr == md_mult) || (mdctr == md_div);
        w_ea     = {{32{w_signed & a[31]}}, a};
        w_eb     = {{32{w_signed & b[31]}}, b};
        w_prod   = w_ea * w_eb;
        dz       = is_div_op(mdctr) && (b == '0);
        w_neg_a  = w_signed & a[31];
        w_neg_b  = w_signed & b[31];
        w_mag_a  = w_neg_a ? (-a) : a;
        w_mag_b  = w_neg_b ? (-b) : b;
        if (w_mag_b == '0) begin
            w_mag_b = 32'd1;
        end
        w_q  = w_mag_a / w_mag_b;
        w_r  = w_mag_a % w_mag_b;
        w_qs = (w_neg_a ^ w_neg_b) ? (-w_q) : w_q;
        w_rs = w_neg_a ? (-w_r) : w_r;
        rhi  = '0;
        rlo  = '0;
        case (mdctr)
            md_mult, md_multu: {rhi, rlo} = w_prod;
            md_div, md_divu:   {rhi, rlo} = {w_rs, w_qs};
            default:           {rhi, rlo} = '0;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// E-stage multi-cycle multiply/divide unit with HI/LO registers and D-stage stall output.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdctr,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hiwrite,
    input  logic        lowrite,
    input  logic [31:0] wdata,
    input  logic        flush,
    input  logic        md_use_d,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_phi;
    logic [31:0]      r_plo;
    logic             r_pdz;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;

    logic [31:0]      w_rhi;
    logic [31:0]      w_rlo;
    logic             w_dz;
    logic             w_accept;

    md_arith u_arith (
        .a     (a),
        .b     (b),
        .mdctr (mdctr),
        .rhi   (w_rhi),
        .rlo   (w_rlo),
        .dz    (w_dz)
    );

    // Request qualification and externally visible status.
    always_comb begin
        w_accept = (r_state == ST_IDLE) && start && !flush && is_md_op(mdctr);
        busy     = (r_state == ST_RUN);
        stall    = md_use_d & (busy | start);
        hi       = r_hi;
        lo       = r_lo;
    end

    // FSM, latency counter, pending result and HI/LO update.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_phi   <= '0;
            r_plo   <= '0;
            r_pdz   <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_phi   <= w_rhi;
                        r_plo   <= w_rlo;
                        r_pdz   <= w_dz;
                        r_cnt   <= is_div_op(mdctr) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        r_state <= ST_RUN;
                    end else if (!flush) begin
                        if (hiwrite) r_hi <= wdata;
                        if (lowrite) r_lo <= wdata;
                    end
                end
                ST_RUN: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        if (!r_pdz) begin
                            r_hi <= r_phi;
                            r_lo <= r_plo;
                        end
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed, table-driven bench for md_unit with hand-computed HI/LO results.
module tb_md_unit;
    import md_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start, hiwrite, lowrite, flush, md_use_d;
    logic [2:0]  mdctr;
    logic [31:0] a, b, wdata;
    logic        busy, stall;
    logic [31:0] hi, lo;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int unsigned cyc;
        string       name;
    } vec_t;

    vec_t vecs[10];

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mdctr    (mdctr),
        .a        (a),
        .b        (b),
        .hiwrite  (hiwrite),
        .lowrite  (lowrite),
        .wdata    (wdata),
        .flush    (flush),
        .md_use_d (md_use_d),
        .busy     (busy),
        .stall    (stall),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at a negedge with busy low; returns at the negedge where busy has fallen.
    task automatic do_op(input vec_t v, input logic fl_run, input logic hw_run);
        int unsigned n;
        start    = 1'b1;
        mdctr    = v.op;
        a        = v.a;
        b        = v.b;
        md_use_d = 1'b1;
        #1 check({v.name, " stall@start"}, 64'(stall), 64'd1);
        @(negedge clk);
        start   = 1'b0;
        flush   = fl_run;
        hiwrite = hw_run;
        wdata   = 32'hDEADBEEF;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            if (n == 0) check({v.name, " stall@busy"}, 64'(stall), 64'd1);
            n++;
            @(negedge clk);
        end
        flush   = 1'b0;
        hiwrite = 1'b0;
        check({v.name, " busy_cycles"}, 64'(n), 64'(v.cyc));
        check({v.name, " stall@fall"}, 64'(stall), 64'd0);
        check({v.name, " hi"}, 64'(hi), 64'(v.hi));
        check({v.name, " lo"}, 64'(lo), 64'(v.lo));
        md_use_d = 1'b0;
    endtask

    task automatic write_hilo(input logic hw, input logic lw, input logic [31:0] d,
                              input logic [31:0] ehi, input logic [31:0] elo);
        hiwrite = hw;
        lowrite = lw;
        wdata   = d;
        @(negedge clk);
        hiwrite = 1'b0;
        lowrite = 1'b0;
        check("mt hi", 64'(hi), 64'(ehi));
        check("mt lo", 64'(lo), 64'(elo));
    endtask

    task automatic ignored_start(input string nm, input logic [2:0] op, input logic fl,
                                 input logic [31:0] ehi, input logic [31:0] elo);
        start = 1'b1;
        mdctr = op;
        a     = 32'd2;
        b     = 32'd3;
        flush = fl;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check({nm, " busy"}, 64'(busy), 64'd0);
        @(negedge clk);
        check({nm, " busy2"}, 64'(busy), 64'd0);
        check({nm, " hi"}, 64'(hi), 64'(ehi));
        check({nm, " lo"}, 64'(lo), 64'(elo));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int unsigned nb;
        vecs[0] = '{md_mult,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5,  "mult -2*3"};
        vecs[1] = '{md_multu, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 5,  "multu"};
        vecs[2] = '{md_div,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10, "div -7/2"};
        vecs[3] = '{md_divu,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 10, "divu big"};
        vecs[4] = '{md_div,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10, "div ovf"};
        vecs[5] = '{md_div,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10, "div 7/-2"};
        vecs[6] = '{md_mult,  32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5,  "mult 2^32"};
        vecs[7] = '{md_multu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5,  "multu max"};
        vecs[8] = '{md_mult,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 5,  "mult -1*-1"};
        vecs[9] = '{md_divu,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10, "divu 100/7"};

        reset = 1'b1; start = 1'b0; hiwrite = 1'b0; lowrite = 1'b0; flush = 1'b0;
        md_use_d = 1'b0; mdctr = '0; a = '0; b = '0; wdata = '0;
        repeat (2) @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Back-to-back: each op starts in the cycle the previous busy falls.
        for (int i = 0; i < 10; i++) do_op(vecs[i], 1'b0, 1'b0);

        ignored_start("flush start", md_mult, 1'b1, 32'h00000002, 32'h0000000E);
        ignored_start("bad mdctr", 3'b111, 1'b0, 32'h00000002, 32'h0000000E);

        do_op('{md_mult, 32'd6, 32'd7, 32'd0, 32'd42, 5, "flush in run"}, 1'b1, 1'b0);
        do_op('{md_multu, 32'd2, 32'd3, 32'd0, 32'd6, 5, "hiwrite in busy"}, 1'b0, 1'b1);

        write_hilo(1'b1, 1'b0, 32'h11, 32'h11, 32'd6);
        write_hilo(1'b0, 1'b1, 32'h22, 32'h11, 32'h22);
        do_op('{md_divu, 32'd5, 32'd0, 32'h11, 32'h22, 10, "divu by 0"}, 1'b0, 1'b0);
        do_op('{md_div, 32'hFFFFFFF0, 32'd0, 32'h11, 32'h22, 10, "div by 0"}, 1'b0, 1'b0);
        write_hilo(1'b1, 1'b1, 32'h33, 32'h33, 32'h33);

        // Reset pulsed in the third busy cycle of a divide.
        start = 1'b1; mdctr = md_divu; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst mid busy", 64'(busy), 64'd0);
        check("rst mid hi", 64'(hi), 64'd0);
        check("rst mid lo", 64'(lo), 64'd0);
        nb = 0;
        repeat (12) begin
            @(negedge clk);
            if (busy !== 1'b0) nb++;
        end
        check("rst no busy", 64'(nb), 64'd0);
        check("rst no commit hi", 64'(hi), 64'd0);
        check("rst no commit lo", 64'(lo), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/md_unit.md
# md_unit

Multi-cycle multiply/divide unit with HI/LO registers for the E stage of the pipelined MIPS core. It accepts the decoded `start`/`mdctr`/`hiwrite`/`lowrite` controls for the instruction in E and runs mult/multu for a fixed number of cycles, or div/divu for a longer fixed number. It holds `busy` while an operation is in flight and raises `stall` toward the hazard unit. HI/LO are read combinationally by the E-stage output mux for mfhi/mflo.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu (must be ≥1).
- `DIV_CYCLES`, default 10: busy cycles for div/divu (must be ≥1).

- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: E-stage instruction is mult/multu/div/divu.
- `mdctr` in 3: operation code, `md_mult`/`md_multu`/`md_div`/`md_divu`.
- `a` in 32: rs operand (dividend / multiplicand).
- `b` in 32: rt operand (divisor / multiplier).
- `hiwrite` in 1: mthi in E.
- `lowrite` in 1: mtlo in E.
- `wdata` in 32: rs value for mthi/mtlo.
- `flush` in 1: E instruction is cancelled by an exception or interrupt this cycle.
- `md_use_d` in 1: D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- `busy` out 1: operation in flight.
- `stall` out 1: `md_use_d & (busy | start)`; combinational.
- `hi` out 32: HI register.
- `lo` out 32: LO register.

## Operation
- **States:**
  - IDLE: `busy`=0.
  - RUN: `busy`=1, down-counter `cnt` counting.
- **Accept:** in IDLE with `start & !flush` and a valid `mdctr`:
  - latch the computed result into pending `phi`/`plo`;
  - load `cnt` with `MULT_CYCLES` or `DIV_CYCLES`;
  - go to RUN.
- **RUN:** `cnt` decrements every cycle. On the edge where `cnt`==1, commit `phi`/`plo` to `hi`/`lo` and return to IDLE.
- **Arithmetic:**
  - mult: signed 32×32→64 product; multu: unsigned product. `hi`=[63:32], `lo`=[31:0].
  - div: signed, `lo`=quotient truncated toward zero, `hi`=remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - div of 0x80000000 by 0xFFFFFFFF: `lo`=0x80000000, `hi`=0.
  - Divide by zero (either signedness): the operation still runs the full `DIV_CYCLES`, then HI/LO stay unchanged.
- **mthi/mtlo:** in IDLE with `!flush`, `hiwrite` writes `wdata` to `hi` and `lowrite` writes `wdata` to `lo` at the edge. If both are asserted together, both registers are written.
- **Ignored requests:**
  - `start` while `busy` (the hazard unit prevents this).
  - `hiwrite`/`lowrite` while `busy`.
  - `start` with an invalid `mdctr`.
  - `start`, `hiwrite` or `lowrite` in a cycle with `flush`=1.
- **Flush and in-flight operations:** `flush` never aborts an operation already in RUN; its instruction has already committed past E.
- **Simultaneous `start` and `hiwrite`/`lowrite`:** cannot occur from decode. If forced, `start` wins and the writes are dropped.

## Timing
- **Reset** (synchronous; also mid-operation): `hi`=0, `lo`=0, `busy`=0, state IDLE, `cnt`=0, pending result discarded.
- **Operation latency:** `start` accepted at edge T, so `busy`=1 for cycles T+1 … T+N (N = `MULT_CYCLES` or `DIV_CYCLES`). The new HI/LO are visible from cycle T+N+1, the same cycle `busy` falls.
- **Back-to-back:** a new `start` is accepted in the cycle `busy` falls. No idle bubble is required.
- **mthi/mtlo:** the written value is visible on `hi`/`lo` the cycle after the write edge.
- **`stall`:** purely combinational, with no registered delay. It is asserted in the start cycle itself, so a D-stage mf*/mt*/md instruction cannot enter E before the result commits.

## Structure
- **Shared header** (the existing `head.v`) holds:
  - `md_mult`=3'b001, `md_multu`=3'b010, `md_div`=3'b011, `md_divu`=3'b100;
  - defaults for `MULT_CYCLES` and `DIV_CYCLES`.
- **Sub-module `md_arith`:** combinational. Inputs `a`, `b`, `mdctr`; outputs 64-bit `{rhi, rlo}` and a `dz` divide-by-zero flag.
- **`md_unit`** holds the state register, counter, pending registers, HI/LO and stall logic.

## Test plan
- **mult latency:** mult `a`=0xFFFFFFFE (−2), `b`=3.
  - `busy` is high for exactly 5 cycles.
  - Then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA.
  - multu with the same operands gives `hi`=0x00000002, `lo`=0xFFFFFFFA.
- **div signs:** div `a`=−7, `b`=2.
  - After 10 busy cycles, `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - divu 0x80000000/0xFFFFFFFF gives `lo`=0, `hi`=0x80000000.
- **Divide by zero:** preload `hi`=0x11, `lo`=0x22 via mthi/mtlo, then divu by 0.
  - `busy` is high for 10 cycles.
  - `hi`/`lo` remain 0x11/0x22.
- **Stall and ignored requests:**
  - `md_use_d`=1 during the start cycle and during `busy` gives `stall`=1; `stall` drops the cycle `busy` falls.
  - `hiwrite` during `busy` leaves `hi` unchanged.
- **Flush:** `start` with `flush`=1.
  - No `busy`, HI/LO unchanged.
  - `flush` during RUN still commits the result on time.
- **Reset mid-operation:** `reset` pulsed at cycle 3 of a div gives `busy`=0, `hi`=`lo`=0 on the next cycle, and no later commit.
